// File: rtl/rhythm_pkg.sv
// rtl/rhythm_pkg.sv - shared grade/state types, window defaults and saturating counters for hit judging
package rhythm_pkg;

  localparam int DEF_PERFECT_WIN = 2;
  localparam int DEF_GOOD_WIN    = 5;
  localparam int SCORE_MAX       = 8191;
  localparam int COMBO_MAX       = 999;

  typedef enum logic [1:0] {
    GRADE_NONE    = 2'd0,
    GRADE_MISS    = 2'd1,
    GRADE_GOOD    = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [12:0] score_add(input logic [12:0] score, input logic [1:0] inc);
    logic [13:0] sum;
    sum = {1'b0, score} + {12'd0, inc};
    score_add = (sum > 14'(SCORE_MAX)) ? 13'(SCORE_MAX) : sum[12:0];
  endfunction

  function automatic logic [9:0] combo_inc(input logic [9:0] combo);
    combo_inc = (combo >= 10'(COMBO_MAX)) ? 10'(COMBO_MAX) : combo + 10'd1;
  endfunction

endpackage

// File: rtl/judge_window_cmp.sv
// rtl/judge_window_cmp.sv - combinational timing-window classifier for one lane's head note
module judge_window_cmp
  import rhythm_pkg::*;
#(
  parameter int PERFECT_WIN = DEF_PERFECT_WIN,
  parameter int GOOD_WIN    = DEF_GOOD_WIN
) (
  input  logic signed [16:0] diff,
  input  logic               note_valid,
  input  logic               press,
  output grade_e             grade,
  output logic               pop
);

  logic [16:0] mag;
  logic        late;

  // diff spans +/-65535, so negating never overflows 17 bits
  assign mag  = diff[16] ? 17'(-diff) : 17'(diff);
  assign late = !diff[16] && (mag > 17'(GOOD_WIN));

  always_comb begin
    grade = GRADE_NONE;
    pop   = 1'b0;
    if (note_valid && press && (mag <= 17'(PERFECT_WIN))) begin
      grade = GRADE_PERFECT;
      pop   = 1'b1;
    end else if (note_valid && press && (mag <= 17'(GOOD_WIN))) begin
      grade = GRADE_GOOD;
      pop   = 1'b1;
    end else if (note_valid && late) begin
      grade = GRADE_MISS;
      pop   = 1'b1;
    end
  end

endmodule

// File: rtl/hit_judge.sv
// rtl/hit_judge.sv - per-frame four-lane hit judge: scans lanes D,F,J,K, grades presses, keeps score and combo
module hit_judge
  import rhythm_pkg::*;
#(
  parameter int PERFECT_WIN = DEF_PERFECT_WIN,
  parameter int GOOD_WIN    = DEF_GOOD_WIN
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             new_frame,
  input  logic [3:0]       dfjk,
  input  logic [15:0]      un_time,
  input  logic [3:0]       note_valid,
  input  logic [3:0][15:0] note_time,
  output logic [3:0]       note_pop,
  output logic [12:0]      score,
  output logic [9:0]       combo,
  output logic [1:0]       precise,
  output logic             judge_valid,
  output logic             overrun
);

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] time_q, time_d;
  logic [3:0]  press_q, press_d;
  logic [3:0]  prev_dfjk_q, prev_dfjk_d;
  logic [12:0] score_q, score_d;
  logic [9:0]  combo_q, combo_d;
  grade_e      precise_q, precise_d;
  logic        judge_valid_q, judge_valid_d;
  logic        overrun_q, overrun_d;

  logic signed [16:0] lane_diff;
  grade_e             lane_grade;
  logic               lane_pop;
  logic               scan_active;

  assign scan_active = (state_q == ST_SCAN);
  assign lane_diff   = $signed({1'b0, time_q}) - $signed({1'b0, note_time[lane_q]});

  judge_window_cmp #(
    .PERFECT_WIN(PERFECT_WIN),
    .GOOD_WIN   (GOOD_WIN)
  ) u_cmp (
    .diff      (lane_diff),
    .note_valid(note_valid[lane_q]),
    .press     (press_q[lane_q]),
    .grade     (lane_grade),
    .pop       (lane_pop)
  );

  // pop is decoded from state so an asynchronous reset silences it immediately
  assign note_pop = (scan_active && lane_pop) ? (4'b0001 << lane_q) : 4'b0000;

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    time_d        = time_q;
    press_d       = press_q;
    prev_dfjk_d   = prev_dfjk_q;
    score_d       = score_q;
    combo_d       = combo_q;
    precise_d     = precise_q;
    judge_valid_d = 1'b0;
    overrun_d     = overrun_q | (new_frame && (state_q != ST_IDLE));

    case (state_q)
      ST_IDLE: begin
        if (new_frame) begin
          time_d      = un_time;
          press_d     = dfjk & ~prev_dfjk_q;
          prev_dfjk_d = dfjk;
          lane_d      = 2'd0;
          state_d     = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (lane_grade != GRADE_NONE) begin
          judge_valid_d = 1'b1;
          precise_d     = lane_grade;
        end
        case (lane_grade)
          GRADE_PERFECT: begin
            score_d = score_add(score_q, 2'd3);
            combo_d = combo_inc(combo_q);
          end
          GRADE_GOOD: begin
            score_d = score_add(score_q, 2'd1);
            combo_d = combo_inc(combo_q);
          end
          GRADE_MISS: combo_d = 10'd0;
          default: ;
        endcase
        if (lane_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          lane_d = lane_q + 2'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      lane_q        <= 2'd0;
      time_q        <= 16'd0;
      press_q       <= 4'd0;
      prev_dfjk_q   <= 4'd0;
      score_q       <= 13'd0;
      combo_q       <= 10'd0;
      precise_q     <= GRADE_NONE;
      judge_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      lane_q        <= lane_d;
      time_q        <= time_d;
      press_q       <= press_d;
      prev_dfjk_q   <= prev_dfjk_d;
      score_q       <= score_d;
      combo_q       <= combo_d;
      precise_q     <= precise_d;
      judge_valid_q <= judge_valid_d;
      overrun_q     <= overrun_d;
    end
  end

  assign score       = score_q;
  assign combo       = combo_q;
  assign precise     = precise_q;
  assign judge_valid = judge_valid_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_hit_judge.sv
// tb/tb_hit_judge.sv - scoreboard bench for hit_judge with a reference model of the grading rules
module tb_hit_judge;

  localparam int PW = 2;
  localparam int GW = 5;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             new_frame = 1'b0;
  logic [3:0]       dfjk = 4'd0;
  logic [15:0]      un_time = 16'd0;
  logic [3:0]       note_valid = 4'd0;
  logic [3:0][15:0] note_time = '0;
  logic [3:0]       note_pop;
  logic [12:0]      score;
  logic [9:0]       combo;
  logic [1:0]       precise;
  logic             judge_valid;
  logic             overrun;

  always #10 clk = ~clk;

  hit_judge #(.PERFECT_WIN(PW), .GOOD_WIN(GW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .new_frame  (new_frame),
    .dfjk       (dfjk),
    .un_time    (un_time),
    .note_valid (note_valid),
    .note_time  (note_time),
    .note_pop   (note_pop),
    .score      (score),
    .combo      (combo),
    .precise    (precise),
    .judge_valid(judge_valid),
    .overrun    (overrun)
  );

  typedef struct {
    int g;
    int sc;
    int cb;
  } jev_t;

  jev_t exp_j[$];
  int   exp_pop[$];
  int   errors = 0;
  int   checks = 0;

  int         m_score = 0;
  int         m_combo = 0;
  logic [3:0] m_prev = 4'd0;
  int         m_precise = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (note_pop[i]) begin
        if (exp_pop.size() == 0) check("unexpected_pop_lane", i, -1);
        else check("pop_lane", i, exp_pop.pop_front());
      end
    end
    if (judge_valid) begin
      if (exp_j.size() == 0) begin
        check("unexpected_judge_precise", int'(precise), -1);
      end else begin
        jev_t e;
        e = exp_j.pop_front();
        check("judge_precise", int'(precise), e.g);
        check("judge_score", int'(score), e.sc);
        check("judge_combo", int'(combo), e.cb);
      end
    end
  end

  task automatic model_frame(input logic [3:0] d, input logic [15:0] ut, input logic [3:0] v,
                             input logic [3:0][15:0] nt);
    for (int i = 0; i < 4; i++) begin
      int  diff;
      int  ad;
      int  g;
      bit  press;
      press = d[i] && !m_prev[i];
      diff  = int'(ut) - int'(nt[i]);
      ad    = (diff < 0) ? -diff : diff;
      g     = 0;
      if (v[i] && press && ad <= PW) begin
        g = 3;
        m_score = (m_score + 3 > 8191) ? 8191 : m_score + 3;
        m_combo = (m_combo + 1 > 999) ? 999 : m_combo + 1;
      end else if (v[i] && press && ad <= GW) begin
        g = 2;
        m_score = (m_score + 1 > 8191) ? 8191 : m_score + 1;
        m_combo = (m_combo + 1 > 999) ? 999 : m_combo + 1;
      end else if (v[i] && diff > GW) begin
        g = 1;
        m_combo = 0;
      end
      if (g != 0) begin
        exp_pop.push_back(i);
        exp_j.push_back('{g, m_score, m_combo});
        m_precise = g;
      end
    end
    m_prev = d;
  endtask

  task automatic run_frame(input logic [3:0] d, input logic [15:0] ut, input logic [3:0] v,
                           input logic [3:0][15:0] nt, input bit overlap);
    @(negedge clk);
    dfjk       = d;
    un_time    = ut;
    note_valid = v;
    note_time  = nt;
    model_frame(d, ut, v, nt);
    new_frame  = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    if (overlap) begin
      @(negedge clk);
      new_frame = 1'b1;
      @(negedge clk);
      new_frame = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("precise_after_frame", int'(precise), m_precise);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n   = 1'b0;
    m_score   = 0;
    m_combo   = 0;
    m_prev    = 4'd0;
    m_precise = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [3:0][15:0] all_at(input logic [15:0] t);
    logic [3:0][15:0] r;
    for (int i = 0; i < 4; i++) r[i] = t;
    return r;
  endfunction

  initial begin
    logic [3:0][15:0] nt;
    logic [15:0]      ut;
    logic [3:0]       v;
    logic [3:0]       d;

    repeat (2) @(negedge clk);
    check("reset_score", int'(score), 0);
    check("reset_combo", int'(combo), 0);
    check("reset_precise", int'(precise), 0);
    check("reset_judge_valid", int'(judge_valid), 0);
    check("reset_note_pop", int'(note_pop), 0);
    check("reset_overrun", int'(overrun), 0);
    reset_n = 1'b1;
    @(negedge clk);

    nt = all_at(16'd0);
    nt[0] = 16'd100;
    run_frame(4'b0001, 16'd101, 4'b0001, nt, 1'b0);
    check("perfect_lane0_score", int'(score), 3);
    check("perfect_lane0_combo", int'(combo), 1);
    check("perfect_lane0_precise", int'(precise), 3);

    nt = all_at(16'd0);
    nt[2] = 16'd100;
    run_frame(4'b0100, 16'd104, 4'b0100, nt, 1'b0);
    check("good_lane2_score", int'(score), 4);
    check("good_lane2_precise", int'(precise), 2);
    run_frame(4'b0000, 16'd106, 4'b0100, nt, 1'b0);
    check("miss_lane2_combo", int'(combo), 0);
    check("miss_lane2_precise", int'(precise), 1);

    do_reset();
    for (int f = 0; f < 3; f++) run_frame(4'b1111, 16'd500, 4'b1111, all_at(16'd500), 1'b0);
    check("held_keys_score", int'(score), 12);
    check("held_keys_combo", int'(combo), 4);
    check("held_keys_precise", int'(precise), 3);

    run_frame(4'b0000, 16'd150, 4'b0000, all_at(16'd0), 1'b0);
    nt = all_at(16'd0);
    nt[1] = 16'd200;
    run_frame(4'b0010, 16'd150, 4'b0010, nt, 1'b0);
    check("early_press_score", int'(score), 12);

    for (int f = 0; f < 80; f++) begin
      ut = 16'($urandom_range(100, 60000));
      for (int i = 0; i < 4; i++) nt[i] = 16'(int'(ut) + int'($urandom_range(0, 16)) - 8);
      v = 4'($urandom);
      d = 4'($urandom);
      run_frame(d, ut, v, nt, 1'b0);
    end

    run_frame(4'b0000, 16'd300, 4'b0000, all_at(16'd0), 1'b0);
    run_frame(4'b0001, 16'd300, 4'b0001, all_at(16'd300), 1'b1);
    check("overrun_set", int'(overrun), 1);

    nt = all_at(16'd0);
    nt[3] = 16'd700;
    @(negedge clk);
    dfjk       = 4'b1000;
    un_time    = 16'd700;
    note_valid = 4'b1000;
    note_time  = nt;
    new_frame  = 1'b1;
    @(negedge clk);
    new_frame = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midscan_score", int'(score), 0);
    check("midscan_combo", int'(combo), 0);
    check("midscan_precise", int'(precise), 0);
    check("midscan_judge_valid", int'(judge_valid), 0);
    check("midscan_note_pop", int'(note_pop), 0);
    check("midscan_overrun", int'(overrun), 0);
    m_score   = 0;
    m_combo   = 0;
    m_prev    = 4'd0;
    m_precise = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    run_frame(4'b1000, 16'd700, 4'b1000, nt, 1'b0);
    check("post_reset_score", int'(score), 3);

    do_reset();
    for (int k = 0; k < 682; k++) begin
      run_frame(4'b1111, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
      run_frame(4'b0000, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    end
    run_frame(4'b0011, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    check("preload_score", int'(score), 8190);
    check("preload_combo", int'(combo), 999);
    run_frame(4'b0000, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    run_frame(4'b0001, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    check("sat_score", int'(score), 8191);
    check("sat_combo", int'(combo), 999);
    run_frame(4'b0000, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    run_frame(4'b0001, 16'd1000, 4'b1111, all_at(16'd1000), 1'b0);
    check("sat_hold_score", int'(score), 8191);

    repeat (4) @(negedge clk);
    check("judge_queue_drained", exp_j.size(), 0);
    check("pop_queue_drained", exp_pop.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
